// File: rtl/piano_pkg.sv
// piano_pkg
// Shared definitions for the piano design: ROM entry field widths, note
// codes, the sequencer state encoding and the note -> half-period lookup
// used by the buzzer tone stage.
package piano_pkg;

    localparam int NOTE_W  = 4;
    localparam int BEATS_W = 4;
    localparam int ENTRY_W = NOTE_W + BEATS_W;
    localparam int HALF_W  = 18;
    localparam int CNT_W   = 32;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Buzzer toggle interval in clocks; codes outside C4..C5 are rests (0).
    function automatic logic [HALF_W-1:0] half_period_of(input logic [NOTE_W-1:0] note);
        logic [HALF_W-1:0] hp;
        case (note)
            NOTE_C4: hp = 18'd191110;
            NOTE_D4: hp = 18'd170265;
            NOTE_E4: hp = 18'd151685;
            NOTE_F4: hp = 18'd143172;
            NOTE_G4: hp = 18'd127551;
            NOTE_A4: hp = 18'd113636;
            NOTE_B4: hp = 18'd101239;
            NOTE_C5: hp = 18'd95556;
            default: hp = '0;
        endcase
        return hp;
    endfunction

    function automatic logic is_audible(input logic [NOTE_W-1:0] note);
        return (note >= NOTE_C4) && (note <= NOTE_C5);
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom
// Registered song ROM, one-cycle read latency. Each entry is {note[7:4],
// beats[3:0]}. Either the built-in tune (case table) or a caller-supplied
// packed image (entry i at bits [8*i +: 8]) is used.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears the read register)
//   addr  - read address, sampled on the rising edge
//   data  - registered entry for the address sampled on the previous edge
module song_rom
    import piano_pkg::*;
#(
    parameter int                            SONG_LEN   = 32,
    parameter bit                            USE_CUSTOM = 1'b0,
    parameter logic [ENTRY_W*SONG_LEN-1:0]   CUSTOM     = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(SONG_LEN)-1:0] addr,
    output logic [ENTRY_W-1:0]          data
);

    logic [ENTRY_W-1:0] entry_d;
    logic [ENTRY_W-1:0] data_q;

    always_comb begin
        entry_d = '0;
        if (USE_CUSTOM) begin
            entry_d = CUSTOM[int'(addr)*ENTRY_W +: ENTRY_W];
        end else begin
            // Built-in tune: "Twinkle Twinkle", then a rest, then end marker.
            case (int'(addr))
                0:       entry_d = {NOTE_C4, 4'd1};
                1:       entry_d = {NOTE_C4, 4'd1};
                2:       entry_d = {NOTE_G4, 4'd1};
                3:       entry_d = {NOTE_G4, 4'd1};
                4:       entry_d = {NOTE_A4, 4'd1};
                5:       entry_d = {NOTE_A4, 4'd1};
                6:       entry_d = {NOTE_G4, 4'd2};
                7:       entry_d = {NOTE_F4, 4'd1};
                8:       entry_d = {NOTE_F4, 4'd1};
                9:       entry_d = {NOTE_E4, 4'd1};
                10:      entry_d = {NOTE_E4, 4'd1};
                11:      entry_d = {NOTE_D4, 4'd1};
                12:      entry_d = {NOTE_D4, 4'd1};
                13:      entry_d = {NOTE_C4, 4'd2};
                14:      entry_d = {NOTE_REST, 4'd2};
                default: entry_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= entry_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer
// Autonomous tune player. Walks the song ROM, enabling the buzzer tone
// stage for each entry's duration with that note's half-period, and
// inserting a silent gap after every entry.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   start       - begin playback at entry 0 (ignored while busy)
//   stop        - abort playback (wins over everything)
//   loop        - at end of song, wrap to entry 0 instead of finishing
//   tone_en     - buzzer counter enable
//   half_period - buzzer toggle interval in clocks (0 for rests)
//   note_idx    - current note code for the LED display
//   busy        - high whenever not IDLE
//   done        - one-cycle pulse on natural end of song
module melody_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned                 BEAT_CYCLES    = 25_000_000,
    parameter int unsigned                 GAP_CYCLES     = 2_500_000,
    parameter int unsigned                 SONG_LEN       = 32,
    parameter bit                          USE_CUSTOM_ROM = 1'b0,
    parameter logic [ENTRY_W*SONG_LEN-1:0] CUSTOM_ROM     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              tone_en,
    output logic [HALF_W-1:0] half_period,
    output logic [NOTE_W-1:0] note_idx,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(SONG_LEN);

    // Elaboration-time parameter checks.
    if (64'(BEAT_CYCLES) * 64'd15 > 64'hFFFF_FFFF) begin : g_beat_overflow
        $error("melody_sequencer: 15*BEAT_CYCLES does not fit the 32-bit duration counter");
    end
    if (SONG_LEN < 2 || (SONG_LEN & (SONG_LEN - 1)) != 0) begin : g_bad_len
        $error("melody_sequencer: SONG_LEN must be a power of two >= 2");
    end
    if (BEAT_CYCLES == 0 || GAP_CYCLES == 0) begin : g_bad_timing
        $error("melody_sequencer: BEAT_CYCLES and GAP_CYCLES must be non-zero");
    end

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tone_en_q, tone_en_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ENTRY_W-1:0]  rom_data;
    logic [NOTE_W-1:0]   entry_note;
    logic [BEATS_W-1:0]  entry_beats;
    logic                entry_is_end;

    // The ROM is addressed with the next address so that the entry is
    // already registered by the first cycle spent in LOAD.
    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .USE_CUSTOM(USE_CUSTOM_ROM),
        .CUSTOM    (CUSTOM_ROM)
    ) u_rom (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr_d),
        .data (rom_data)
    );

    assign entry_note   = rom_data[ENTRY_W-1:BEATS_W];
    assign entry_beats  = rom_data[BEATS_W-1:0];
    // The last ROM slot ends the song whatever it holds.
    assign entry_is_end = (entry_beats == '0) || (addr_q == AW'(SONG_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            tone_en_q <= 1'b0;
            half_q    <= '0;
            note_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tone_en_q <= tone_en_d;
            half_q    <= half_d;
            note_q    <= note_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tone_en_d = tone_en_q;
        half_d    = half_q;
        note_d    = note_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (entry_is_end) begin
                    addr_d = '0;
                    if (!loop) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        cnt_d     = '0;
                        tone_en_d = 1'b0;
                        half_d    = '0;
                        note_d    = '0;
                    end
                    // With loop set, stay in LOAD so entry 0 is fetched.
                end else begin
                    state_d   = PLAY;
                    cnt_d     = CNT_W'(entry_beats) * CNT_W'(BEAT_CYCLES) - CNT_W'(1);
                    tone_en_d = is_audible(entry_note);
                    half_d    = half_period_of(entry_note);
                    note_d    = entry_note;
                end
            end
            PLAY: begin
                if (cnt_q == '0) begin
                    state_d   = GAP;
                    cnt_d     = CNT_W'(GAP_CYCLES) - CNT_W'(1);
                    tone_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                    addr_d  = addr_q + AW'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d   = IDLE;
            addr_d    = '0;
            cnt_d     = '0;
            tone_en_d = 1'b0;
            half_d    = '0;
            note_d    = '0;
            done_d    = 1'b0;
        end
    end

    assign busy_d = (state_d != IDLE);

    assign tone_en     = tone_en_q;
    assign half_period = half_q;
    assign note_idx    = note_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: each scenario pushes the expected
// per-cycle output tuples when it drives stimulus, then pops and compares
// them against the DUT on every falling clock edge.
module tb_melody_sequencer;

    localparam int BEAT = 8;
    localparam int GAPC = 2;
    localparam int LEN  = 8;

    // Entry i at bits [8*i +: 8]: {6,2},{0,1},{1,1},{0,0}
    localparam logic [63:0] ROM_A = 64'h0000_0000_0011_0162;
    // Seven non-zero entries plus a non-zero entry at the last address.
    localparam logic [63:0] ROM_B = 64'h8171_6151_4131_2111;

    localparam logic [17:0] HP_C4 = 18'd191110;
    localparam logic [17:0] HP_A4 = 18'd113636;

    typedef struct packed {
        logic        tone;
        logic [17:0] half;
        logic [3:0]  note;
        logic        busy;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
    logic start_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
    logic        tone_a, busy_a, done_a, tone_b, busy_b, done_b;
    logic [17:0] half_a, half_b;
    logic [3:0]  note_a, note_b;

    obs_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .SONG_LEN(LEN),
        .USE_CUSTOM_ROM(1'b1), .CUSTOM_ROM(ROM_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .loop(loop_a),
        .tone_en(tone_a), .half_period(half_a), .note_idx(note_a),
        .busy(busy_a), .done(done_a)
    );

    melody_sequencer #(
        .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .SONG_LEN(LEN),
        .USE_CUSTOM_ROM(1'b1), .CUSTOM_ROM(ROM_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .loop(loop_b),
        .tone_en(tone_b), .half_period(half_b), .note_idx(note_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [17:0] ref_hp(input int note);
        case (note)
            1: return 18'd191110;
            2: return 18'd170265;
            3: return 18'd151685;
            4: return 18'd143172;
            5: return 18'd127551;
            6: return 18'd113636;
            7: return 18'd101239;
            8: return 18'd95556;
            default: return 18'd0;
        endcase
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) o = {tone_b, half_b, note_b, busy_b, done_b};
        else     o = {tone_a, half_a, note_a, busy_a, done_a};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("tone=%0b half=%0d note=%0d busy=%0b done=%0b",
                         o.tone, o.half, o.note, o.busy, o.done);
    endfunction

    task automatic push_seg(input logic tone, input logic [17:0] half, input logic [3:0] note,
                            input logic busy, input logic done, input int n);
        obs_t o;
        o = {tone, half, note, busy, done};
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endtask

    // Expected trace of ROM_A played once from the LOAD cycle to done.
    task automatic push_song_a_once();
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);          // LOAD entry 0
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 2*BEAT);     // A4, 2 beats
        push_seg(1'b0, HP_A4, 4'd6, 1'b1, 1'b0, GAPC+1);     // gap + LOAD
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, BEAT);       // rest, 1 beat
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, GAPC+1);
        push_seg(1'b1, HP_C4, 4'd1, 1'b1, 1'b0, BEAT);       // C4, 1 beat
        push_seg(1'b0, HP_C4, 4'd1, 1'b1, 1'b0, GAPC+1);     // gap + end LOAD
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b1, 1);          // done pulse
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 3);          // idle
    endtask

    task automatic step(input bit sel, output obs_t act, output obs_t expv);
        @(negedge clk);
        act  = sample(sel);
        expv = exp_q.pop_front();
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_stop(input bit sel);
        if (sel) stop_b = 1'b1; else stop_a = 1'b1;
        @(posedge clk);
        #1;
        stop_a = 1'b0;
        stop_b = 1'b0;
    endtask

    task automatic test_reset();
        obs_t act, expv;
        int i = 0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 6);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            start_a = 1'($urandom); stop_a = 1'($urandom); loop_a = 1'($urandom);
            start_b = 1'($urandom); stop_b = 1'($urandom); loop_b = 1'($urandom);
            i++;
        end
        vectors++;
        if (sample(1'b1) !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_hold_b: got %s, expected all zero", fmt(sample(1'b1)));
        end
        start_a = 0; stop_a = 0; loop_a = 0; start_b = 0; stop_b = 0; loop_b = 0;
        rst_n = 1'b1;
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 4);          // waits for start
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_play_once();
        obs_t act, expv;
        int i = 0;
        loop_a = 1'b0;
        push_song_a_once();
        pulse_start(1'b0);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL play_once[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_loop();
        obs_t act, expv;
        int i = 0;
        loop_a = 1'b1;
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 2*BEAT);
        push_seg(1'b0, HP_A4, 4'd6, 1'b1, 1'b0, GAPC+1);
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, BEAT);
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, GAPC+1);
        push_seg(1'b1, HP_C4, 4'd1, 1'b1, 1'b0, BEAT);
        push_seg(1'b0, HP_C4, 4'd1, 1'b1, 1'b0, GAPC+2);     // gap + wrap LOAD + LOAD 0
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 2*BEAT);     // entry 0 again, no done
        pulse_start(1'b0);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL loop_wrap[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        loop_a = 1'b0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 3);
        pulse_stop(1'b0);
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL loop_stop[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_stop_mid_note();
        obs_t act, expv;
        int i = 0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 4);
        pulse_start(1'b0);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL stop_pre[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        // stop sampled at the edge closing the 4th PLAY cycle
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 3);
        pulse_stop(1'b0);
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL stop_post[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        // replay starts again from entry 0 with a full-length note
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 2*BEAT);
        push_seg(1'b0, HP_A4, 4'd6, 1'b1, 1'b0, 1);
        pulse_start(1'b0);
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL stop_replay[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 2);
        pulse_stop(1'b0);
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL stop_in_gap[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_start_stop_same();
        obs_t act, expv;
        int i = 0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 3);
        start_a = 1'b1;
        stop_a  = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        stop_a  = 1'b0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL start_stop_same[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_start_while_busy();
        obs_t act, expv;
        int i = 0;
        push_song_a_once();
        pulse_start(1'b0);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL start_busy[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            // re-assert start across several mid-note edges
            if (i == 3) start_a = 1'b1;
            if (i == 8) start_a = 1'b0;
            i++;
        end
    endtask

    task automatic test_end_at_last();
        obs_t act, expv;
        int i = 0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        for (int n = 1; n <= 7; n++) begin
            push_seg(1'b1, ref_hp(n), 4'(n), 1'b1, 1'b0, BEAT);
            push_seg(1'b0, ref_hp(n), 4'(n), 1'b1, 1'b0, GAPC+1);
        end
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b1, 1);
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 4);
        loop_b = 1'b0;
        pulse_start(1'b1);
        while (exp_q.size() != 0) begin
            step(1'b1, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL end_at_last[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_play();
        obs_t act, expv;
        int i = 0;
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 5);
        pulse_start(1'b0);
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL rst_mid_pre[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        // assert reset away from any clock edge; outputs must clear at once
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 1);
        rst_n = 1'b0;
        #1;
        act  = sample(1'b0);
        expv = exp_q.pop_front();
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %s, expected %s", fmt(act), fmt(expv));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 3);           // idle, awaiting start
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL rst_mid_idle[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        // playback after reset restarts at entry 0
        push_seg(1'b0, 18'd0, 4'd0, 1'b1, 1'b0, 1);
        push_seg(1'b1, HP_A4, 4'd6, 1'b1, 1'b0, 2*BEAT);
        push_seg(1'b0, HP_A4, 4'd6, 1'b1, 1'b0, 1);
        pulse_start(1'b0);
        i = 0;
        while (exp_q.size() != 0) begin
            step(1'b0, act, expv);
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL rst_mid_replay[%0d]: got %s, expected %s", i, fmt(act), fmt(expv));
            end
            i++;
        end
        push_seg(1'b0, 18'd0, 4'd0, 1'b0, 1'b0, 1);
        pulse_stop(1'b0);
        step(1'b0, act, expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL rst_mid_stop: got %s, expected %s", fmt(act), fmt(expv));
        end
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop();
        test_stop_mid_note();
        test_start_stop_same();
        test_start_while_busy();
        test_end_at_last();
        test_reset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Autonomous tune player for the piano design. Steps through a fixed song ROM of (note, beats) entries and drives the buzzer tone stage: enables it for each note's duration and supplies that note's half-period divisor. Silent gaps are inserted between notes. Sits directly upstream of the buzzer counter; its `tone_en` feeds the buzzer's `counterE`.

## Interface
- `BEAT_CYCLES`, default 25_000_000: clock cycles per beat (0.25 s at 100 MHz).
- `GAP_CYCLES`, default 2_500_000: silent cycles after each entry.
- `SONG_LEN`, default 32: ROM depth, power of two.
- `clk  in  1`: system clock; one clock domain.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin playback at entry 0; level-sampled.
- `stop  in  1`: abort playback.
- `loop  in  1`: at end of song, restart at entry 0 instead of finishing.
- `tone_en  out  1`: drives the buzzer counter enable.
- `half_period  out  18`: buzzer toggle interval in clocks.
- `note_idx  out  4`: current note code, for the LED display.
- `busy  out  1`: high in any state other than IDLE.
- `done  out  1`: one-cycle pulse on natural end of song.

## Operation
- ROM entry is 8 bits: `note[7:4]`, `beats[3:0]`.
  - `beats==0` marks end of song.
  - The entry at address SONG_LEN-1 is also treated as end, regardless of content.
- Note codes and half-periods:
  - 0 = rest.
  - 1..7 = C4..B4: 191110, 170265, 151685, 143172, 127551, 113636, 101239.
  - 8 = C5: 95556.
  - 9..15 = rest.
- State machine, all outputs registered:
  - IDLE: all outputs 0. `start` goes to LOAD with addr=0.
  - LOAD: one cycle while the ROM read completes (registered ROM).
    - `beats==0` and `loop=1`: addr=0, stay in LOAD.
    - `beats==0` and `loop=0`: go to IDLE and pulse `done`.
    - Otherwise go to PLAY; load the duration counter with beats×BEAT_CYCLES−1.
  - PLAY: `tone_en` = (note is audible); `half_period` from the table, or 0 for a rest; `note_idx` = note.
    - When the counter reaches 0, go to GAP; load GAP_CYCLES−1.
  - GAP: `tone_en`=0; `half_period` and `note_idx` hold.
    - When the counter reaches 0: addr+1, go to LOAD.
- `stop` overrides everything: the next state is IDLE and all outputs clear next edge.
- `start` and `stop` high in the same cycle: `stop` wins.
- `start` while `busy` is ignored; there is no restart mid-song.
- `loop` is sampled only in LOAD.
- Duration counter is 32 bits. beats×BEAT_CYCLES must be < 2^32; this is checked by an elaboration assertion.
- `done` is never asserted on `stop` or on a loop wrap.

## Timing
- `start` sampled at edge k:
  - LOAD after edge k.
  - PLAY after edge k+1; `tone_en` high from edge k+1.
- An entry with b beats holds `tone_en` high for exactly b×BEAT_CYCLES cycles.
- Between consecutive audible notes, `tone_en` is low for exactly GAP_CYCLES+1 cycles (GAP plus LOAD).
- `done` is high for the single cycle after the end-marker LOAD edge; `busy` falls on that same edge.
- `stop` sampled at edge k: `tone_en`, `busy`, `half_period`, `note_idx` are all 0 after edge k.
- `rst_n` low, at any time including mid-PLAY:
  - Immediately: state=IDLE, addr=0, counters=0, all outputs 0.
  - On release, the block waits for `start`.

## Structure
- Shared package `piano_pkg`:
  - Note code constants.
  - Half-period lookup function.
  - Entry field widths.
  - State enum (IDLE, LOAD, PLAY, GAP).
- Sub-module `song_rom`:
  - Registered case-table ROM, `addr` in, `data[7:0]` out, 1-cycle latency.
  - The bench substitutes its own contents.

## Test plan
Bench parameters: BEAT_CYCLES=8, GAP_CYCLES=2, SONG_LEN=8. Test ROM: {6,2}, {0,1}, {1,1}, {0,0}.

- Reset: hold `rst_n` low, toggle inputs. Required: all outputs 0. Assert reset mid-PLAY: outputs 0 immediately, with no clock edge needed.
- Play once: `start` pulse at edge 10, `loop`=0. Required:
  - `tone_en` high edges 11–26, with `half_period`=113636 and `note_idx`=6.
  - Low 3 cycles, then the rest entry: `tone_en` low 8 cycles, `half_period`=0.
  - Low 3 cycles, then `tone_en` high 8 cycles with 191110.
  - Then a single `done` pulse and `busy` low.
- Loop: `loop`=1. Required: after entry 2's gap, entry 0 replays with no `done` pulse.
- Stop mid-note: `stop` at the 4th PLAY cycle of entry 0. Required: `tone_en` and `busy` 0 after that edge; a later `start` replays from entry 0.
- Simultaneous `start`+`stop` in IDLE. Required: stays IDLE. `start` while busy: no effect on addr or counters.
- End at address SONG_LEN-1: ROM with 7 non-zero entries. Required: the entry at address 7 is never played; `done` pulses.
